ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single-port data memory between two requesters: the CPU control unit (STS/LDS traffic) and a secondary master (DMA or debug loader). Round-robin arbitration with a per-requester request/grant/read-valid handshake. Sits between the requesters and rw_memory, which keeps its synchronous one-cycle read.

## Interface
- ADDRESS_WIDTH, 8, width of the data-memory address.
- DATA_WIDTH, 8, width of a memory word.
- MEM_DEPTH, 256, number of implemented words; valid addresses are 0..MEM_DEPTH-1.
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req[1:0]  in  2  access request; index 0 = CPU, index 1 = secondary.
- we[1:0]  in  2  per requester: 1 = write, 0 = read.
- addr0, addr1  in  ADDRESS_WIDTH  per-requester address.
- wdata0, wdata1  in  DATA_WIDTH  per-requester write data.
- gnt[1:0]  out  2  one-hot, one-cycle acceptance of the request.
- rvalid[1:0]  out  2  one-cycle read-data-valid to the granted reader.
- rdata  out  DATA_WIDTH  read data, shared; qualified by rvalid.
- err[1:0]  out  2  one-cycle pulse, out-of-range access, coincident with the response.
- mem_we  out  1  write enable to rw_memory.
- mem_addr  out  ADDRESS_WIDTH  address to rw_memory.
- mem_wdata  out  DATA_WIDTH  write data to rw_memory.
- mem_rdata  in  DATA_WIDTH  rw_memory read data, valid one cycle after address.

## Operation
- FSM states: ARB_IDLE, ARB_READ_WAIT.
- ARB_IDLE, no req: gnt=0, mem_we=0, mem_addr/mem_wdata=0.
- ARB_IDLE, req present: select winner, gnt[w]=1 combinationally, and drive mem_addr/mem_wdata from the winner in the same cycle.
- Winner with we=1 and in range: mem_we=1 that cycle; write completes at the edge; stay in ARB_IDLE. No rvalid.
- Winner with we=0: go to ARB_READ_WAIT and latch the winner index and the range flag.
- ARB_READ_WAIT: rvalid[w]=1, rdata=mem_rdata (0 if out of range), gnt=0, and return to ARB_IDLE. A read costs 2 cycles, and no grant is made during ARB_READ_WAIT.
- Round-robin: register last_gnt. If both request, grant the requester that is not last_gnt. If only one requests, grant it. Update last_gnt on every grant.
- Out of range (addr >= MEM_DEPTH): the access is still granted. A write has mem_we=0 and err[w] pulses in the grant cycle. A read has rdata=0 and err[w] pulses with rvalid.
- Requesters hold req/we/addr/wdata stable until gnt. Deasserting req before gnt is legal and withdraws the request. req sampled in the gnt cycle is consumed; a still-high req on the next cycle is a new request.

## Timing
- Reset (async, reset_n=0): state=ARB_IDLE, last_gnt=1 (CPU wins the first tie). gnt, rvalid, err, mem_we, mem_addr, mem_wdata and rdata are all 0 while reset_n=0, regardless of req.
- Write latency: 0 cycles from req to gnt if the arbiter is idle. Data is in memory after that edge.
- Read latency: gnt in cycle N, rvalid in cycle N+1.
- Back-to-back: a write is followed by a new grant in the next cycle. A read is followed by a new grant in cycle N+2.
- A req rising during ARB_READ_WAIT waits; arbitration happens in the next ARB_IDLE cycle.
- Reset mid-read (in ARB_READ_WAIT): rvalid is not issued. The requester must re-request after reset.
- mem_rdata in ARB_IDLE is ignored.

## Structure
- Add to package def:
  - typedef enum arb_state { ARB_IDLE, ARB_READ_WAIT }
  - localparam REQ_CPU = 0, REQ_SEC = 1
- One sub-module, ram_arbiter_select: combinational winner pick from req[1:0] and last_gnt, outputs one-hot gnt and a valid flag. The FSM, the latches and the memory mux stay in ram_arbiter.

## Test plan
- After reset, both req with we=1: CPU addr=0x10 wdata=0xAA, secondary addr=0x20 wdata=0x55.
  -> gnt=01 in cycle 0 and mem[0x10]=0xAA. gnt=10 in cycle 1 and mem[0x20]=0x55.
- CPU reads 0x10 (holding 0xAA).
  -> gnt[0] in cycle N, rvalid[0]=1 and rdata=0xAA in cycle N+1, no gnt in N+1.
- Secondary reads continuously with the CPU idle, then the CPU asserts req during ARB_READ_WAIT.
  -> The CPU is granted in the next ARB_IDLE. Grants then alternate 01/10 while both requests are held.
- Secondary writes addr=0xFF with MEM_DEPTH=128.
  -> gnt[1]=1, mem_we=0, err[1]=1 in the same cycle. Memory is unchanged.
- Out-of-range read with MEM_DEPTH=128.
  -> rvalid=1, rdata=0x00, err=1.
- Assert reset_n=0 during ARB_READ_WAIT.
  -> All outputs are 0 immediately with no rvalid. After release, a tie grants the CPU first.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state type and
// requester indices.
package ram_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_READ_WAIT
  } arb_state;

  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_SEC = 1;

endpackage

// File: rtl/ram_arbiter_select.sv
// Round-robin winner pick for the two memory requesters.
// Ports:
//   req      - request vector (bit 0 = CPU, bit 1 = secondary)
//   last_gnt - index of the requester granted most recently
//   gnt      - one-hot winner (all zero when nobody requests)
//   valid    - at least one request present
module ram_arbiter_select
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt   = '0;
    valid = |req;
    unique case (req)
      2'b01:   gnt[REQ_CPU] = 1'b1;
      2'b10:   gnt[REQ_SEC] = 1'b1;
      // On a tie the requester that was not served last wins.
      2'b11:   begin
        if (last_gnt == 1'(REQ_SEC)) gnt[REQ_CPU] = 1'b1;
        else                         gnt[REQ_SEC] = 1'b1;
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data memory between the CPU control unit and a
// secondary master. Writes complete in the grant cycle; reads take a second
// cycle to return rw_memory's registered read data.
// Ports:
//   clock, reset_n         - clock, async active-low reset
//   req, we                - per-requester request / write select
//   addr0/addr1            - per-requester address
//   wdata0/wdata1          - per-requester write data
//   gnt                    - one-hot one-cycle acceptance
//   rvalid, rdata          - read response (rdata shared, qualified by rvalid)
//   err                    - out-of-range pulse, coincident with the response
//   mem_we/mem_addr/mem_wdata/mem_rdata - rw_memory port
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MEM_DEPTH     = 256
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [1:0]               req,
  input  logic [1:0]               we,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic [1:0]               gnt,
  output logic [1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  arb_state state_q, state_d;
  logic     last_gnt_q;
  logic     rd_idx_q;
  logic     rd_oor_q;

  logic [1:0]               sel_gnt;
  logic                     sel_valid;
  logic                     win_idx;
  logic                     win_we;
  logic [ADDRESS_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]    win_wdata;
  logic                     win_in_range;
  logic                     grant_fire;

  ram_arbiter_select u_select (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (sel_gnt),
    .valid    (sel_valid)
  );

  assign win_idx      = sel_gnt[REQ_SEC];
  assign win_we       = we[win_idx];
  assign win_addr     = win_idx ? addr1 : addr0;
  assign win_wdata    = win_idx ? wdata1 : wdata0;
  assign win_in_range = 32'(win_addr) < MEM_DEPTH;
  assign grant_fire   = (state_q == ARB_IDLE) && sel_valid;

  // Outputs are gated by reset_n so they read zero throughout reset even
  // though req feeds the grant path combinationally.
  always_comb begin
    state_d   = state_q;
    gnt       = '0;
    rvalid    = '0;
    err       = '0;
    rdata     = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset_n) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (sel_valid) begin
            gnt       = sel_gnt;
            mem_addr  = win_addr;
            mem_wdata = win_wdata;
            if (win_we) begin
              mem_we       = win_in_range;
              err[win_idx] = ~win_in_range;
            end else begin
              state_d = ARB_READ_WAIT;
            end
          end
        end
        ARB_READ_WAIT: begin
          rvalid[rd_idx_q] = 1'b1;
          err[rd_idx_q]    = rd_oor_q;
          rdata            = rd_oor_q ? '0 : mem_rdata;
          state_d          = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= 1'(REQ_SEC);
      rd_idx_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        last_gnt_q <= win_idx;
        if (!win_we) begin
          rd_idx_q <= win_idx;
          rd_oor_q <= ~win_in_range;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int DEPTH = 128;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] req, we;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [1:0] gnt, rvalid, err;
  logic [7:0] rdata;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  ram_arbiter #(
    .ADDRESS_WIDTH (8),
    .DATA_WIDTH    (8),
    .MEM_DEPTH     (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .err       (err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // rw_memory stand-in: synchronous write, registered one-cycle read.
  logic [7:0] mem [256];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference model state (transaction level).
  logic [7:0] ref_mem [256];
  int         m_last;
  bit         m_pend;
  int         m_pend_who;
  bit         m_pend_oor;
  logic [7:0] m_pend_data;
  logic [1:0] exp_gnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock cycle, entered just after a falling edge. Drives the inputs,
  // checks outputs mid-low-phase against the model, then advances the model.
  task automatic cycle(input logic [1:0] r, input logic [1:0] wv,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] a [2];
    logic [7:0] d [2];
    int w;
    bit oor;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    req = r; we = wv; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    #2;
    exp_gnt = 2'b00;
    if (m_pend) begin
      check("gnt_rdwait", 32'(gnt), 32'd0);
      check("rvalid", 32'(rvalid), 32'(1 << m_pend_who));
      check("rdata", 32'(rdata), 32'(m_pend_data));
      check("err_rd", 32'(err), m_pend_oor ? 32'(1 << m_pend_who) : 32'd0);
      check("mem_we_rdwait", 32'(mem_we), 32'd0);
      @(posedge clock);
      m_pend = 1'b0;
    end else if (r == 2'b00) begin
      check("gnt_idle", 32'(gnt), 32'd0);
      check("rvalid_idle", 32'(rvalid), 32'd0);
      check("err_idle", 32'(err), 32'd0);
      check("mem_we_idle", 32'(mem_we), 32'd0);
      check("mem_addr_idle", 32'(mem_addr), 32'd0);
      check("mem_wdata_idle", 32'(mem_wdata), 32'd0);
      @(posedge clock);
    end else begin
      if (r == 2'b11) w = (m_last == 1) ? 0 : 1;
      else            w = r[1] ? 1 : 0;
      oor = (int'(a[w]) >= DEPTH);
      exp_gnt = 2'(1 << w);
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("rvalid_gnt", 32'(rvalid), 32'd0);
      check("mem_addr", 32'(mem_addr), 32'(a[w]));
      check("mem_wdata", 32'(mem_wdata), 32'(d[w]));
      check("mem_we", 32'(mem_we), (wv[w] && !oor) ? 32'd1 : 32'd0);
      check("err_wr", 32'(err), (wv[w] && oor) ? 32'(exp_gnt) : 32'd0);
      @(posedge clock);
      m_last = w;
      if (wv[w]) begin
        if (!oor) ref_mem[a[w]] = d[w];
      end else begin
        m_pend      = 1'b1;
        m_pend_who  = w;
        m_pend_oor  = oor;
        m_pend_data = oor ? 8'h00 : ref_mem[a[w]];
      end
    end
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  bit         act [2];
  logic       tw  [2];
  logic [7:0] ta  [2];
  logic [7:0] td  [2];

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    m_last = 1; m_pend = 1'b0;

    // Reset with both requesting: everything must read zero.
    reset_n = 1'b0;
    req = 2'b11; we = 2'b11; addr0 = 8'h10; addr1 = 8'h20; wdata0 = 8'hAA; wdata1 = 8'h55;
    @(negedge clock);
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Tie of writes: CPU first, then secondary.
    cycle(2'b11, 2'b11, 8'h10, 8'h20, 8'hAA, 8'h55);
    check("mem10", 32'(mem[8'h10]), 32'h0AA);
    cycle(2'b10, 2'b11, 8'h10, 8'h20, 8'hAA, 8'h55);
    check("mem20", 32'(mem[8'h20]), 32'h055);

    // CPU read of 0x10.
    cycle(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Secondary reading, CPU joins during the read wait; grants alternate.
    cycle(2'b10, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++)
      cycle(2'b11, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00);

    // Out-of-range write from the secondary.
    cycle(2'b10, 2'b10, 8'h00, 8'hFF, 8'h00, 8'h3C);
    check("memFF", 32'(mem[8'hFF]), 32'(ref_mem[8'hFF]));

    // Out-of-range read from the CPU.
    cycle(2'b01, 2'b00, 8'h90, 8'h00, 8'h00, 8'h00);
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset asserted during the read wait.
    cycle(2'b01, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00);
    req = 2'b11; we = 2'b11;
    #2 reset_n = 1'b0;
    #1 check_all_zero("midread");
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    m_pend = 1'b0; m_last = 1;
    cycle(2'b11, 2'b11, 8'h30, 8'h31, 8'h12, 8'h34);

    // Randomised traffic from two well-behaved requesters.
    act[0] = 1'b0; act[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!act[k]) begin
          if ($urandom_range(0, 1) == 1) begin
            act[k] = 1'b1;
            tw[k]  = 1'($urandom_range(0, 1));
            ta[k]  = 8'($urandom_range(0, 159));
            td[k]  = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          act[k] = 1'b0;
        end
      end
      cycle({act[1], act[0]}, {tw[1], tw[0]}, ta[0], ta[1], td[0], td[1]);
      for (int k = 0; k < 2; k++)
        if (exp_gnt[k]) act[k] = 1'b0;
    end
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    cycle(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 256; i++)
      check("mem_final", 32'(mem[i]), 32'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
